// File: rtl/snn_pkg.sv
// Shared SNN definitions: default event field widths, dispatcher state
// encodings and the packed AER event layout.
package snn_pkg;

  localparam int TIME_W_DEF = 8;
  localparam int ADDR_W_DEF = 10;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_DONE = 3'd2;
  localparam logic [2:0] S_ACK       = 3'd3;
  localparam logic [2:0] S_WDONE     = 3'd4;

  typedef struct packed {
    logic [TIME_W_DEF-1:0] t;
    logic [ADDR_W_DEF-1:0] addr;
  } aer_evt_t;

  localparam int AER_EVT_W = $bits(aer_evt_t);

  // Packed {time, addr} width for non-default field widths.
  function automatic int evt_w(input int tw, input int aw);
    return tw + aw;
  endfunction

endpackage

// File: rtl/aer_event_fifo.sv
// Synchronous FIFO with count-based full/empty; pushes are dropped when full,
// pops are dropped when empty.
module aer_event_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 8
) (
  input  logic         local_clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge local_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset; pointers and count define validity.
  always_ff @(posedge local_clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/aer_event_dispatcher.sv
// Buffers AER events and broadcasts them one at a time to NUM_PE PEs, acking
// all PEs together once each has reported done (or the wait times out).
module aer_event_dispatcher
  import snn_pkg::*;
#(
  parameter int TIME_W     = TIME_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int NUM_PE     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 255,
  parameter int CNT_W      = 16
) (
  input  logic              local_clk,
  input  logic              rst_n,
  input  logic              i_evt_valid,
  output logic              o_evt_ready,
  input  logic [TIME_W-1:0] i_evt_time,
  input  logic [ADDR_W-1:0] i_evt_addr,
  input  logic              i_window_end,
  input  logic              i_clear,
  output logic              o_aer_req,
  output logic [TIME_W-1:0] o_aer_time,
  output logic [ADDR_W-1:0] o_aer_addr,
  input  logic [NUM_PE-1:0] i_done_req,
  output logic [NUM_PE-1:0] o_done_ack,
  output logic              o_window_done,
  output logic [CNT_W-1:0]  o_evt_count,
  output logic              o_err,
  output logic              o_busy
);
  localparam int EVT_W = evt_w(TIME_W, ADDR_W);
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [2:0]        state;
  logic [NUM_PE-1:0] done_mask, mask_nxt;
  logic [TO_W-1:0]   tcnt;
  logic              window_pend;
  logic              fifo_pop, fifo_full, fifo_empty;
  logic [EVT_W-1:0]  head;
  logic              all_done, to_hit, ack_fire, to_fire;

  aer_event_fifo #(.W(EVT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .local_clk (local_clk),
    .rst_n     (rst_n),
    .push      (i_evt_valid),
    .pop       (fifo_pop),
    .wdata     ({i_evt_time, i_evt_addr}),
    .rdata     (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign o_evt_ready = !fifo_full;
  assign o_busy      = (state != S_IDLE) || !fifo_empty;
  assign fifo_pop    = (state == S_IDLE) && !fifo_empty;

  // Only done bits seen while waiting are accumulated.
  assign mask_nxt = done_mask | i_done_req;
  assign all_done = &mask_nxt;
  assign to_hit   = (tcnt == TO_LAST);
  assign ack_fire = (state == S_WAIT_DONE) && (all_done || to_hit);
  assign to_fire  = (state == S_WAIT_DONE) && !all_done && to_hit;

  always_ff @(posedge local_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      done_mask     <= '0;
      tcnt          <= '0;
      o_aer_req     <= 1'b0;
      o_aer_time    <= '0;
      o_aer_addr    <= '0;
      o_done_ack    <= '0;
      o_window_done <= 1'b0;
    end else begin
      o_aer_req     <= 1'b0;
      o_done_ack    <= '0;
      o_window_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            {o_aer_time, o_aer_addr} <= head;
            o_aer_req                <= 1'b1;
            state                    <= S_ISSUE;
          end else if (window_pend) begin
            o_window_done <= 1'b1;
            state         <= S_WDONE;
          end
        end
        S_ISSUE: begin
          done_mask <= '0;
          tcnt      <= '0;
          state     <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          done_mask <= mask_nxt;
          if (ack_fire) begin
            o_done_ack <= '1;
            state      <= S_ACK;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_ACK:   state <= S_IDLE;
        S_WDONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Clear wins over a same-cycle increment, error or window request.
  always_ff @(posedge local_clk or negedge rst_n) begin
    if (!rst_n) begin
      o_evt_count <= '0;
      o_err       <= 1'b0;
      window_pend <= 1'b0;
    end else if (i_clear) begin
      o_evt_count <= '0;
      o_err       <= 1'b0;
      window_pend <= 1'b0;
    end else begin
      if (ack_fire) o_evt_count <= o_evt_count + CNT_W'(1);
      if (to_fire)  o_err <= 1'b1;
      if (i_window_end)           window_pend <= 1'b1;
      else if (state == S_WDONE)  window_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aer_event_dispatcher.sv
// Directed bench for aer_event_dispatcher: latency, FIFO fill, window drain,
// PE timeout/clear, async reset mid-event and done-bit sampling window.
module tb_aer_event_dispatcher;
  logic        local_clk = 1'b0;
  logic        rst_n;
  logic        i_evt_valid, i_window_end, i_clear;
  logic        o_evt_ready, o_aer_req, o_window_done, o_err, o_busy;
  logic [7:0]  i_evt_time, o_aer_time;
  logic [9:0]  i_evt_addr, o_aer_addr;
  logic [3:0]  i_done_req, o_done_ack;
  logic [15:0] o_evt_count;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  aer_event_dispatcher #(
    .TIME_W(8), .ADDR_W(10), .NUM_PE(4), .FIFO_DEPTH(8), .TIMEOUT(16), .CNT_W(16)
  ) dut (
    .local_clk     (local_clk),
    .rst_n         (rst_n),
    .i_evt_valid   (i_evt_valid),
    .o_evt_ready   (o_evt_ready),
    .i_evt_time    (i_evt_time),
    .i_evt_addr    (i_evt_addr),
    .i_window_end  (i_window_end),
    .i_clear       (i_clear),
    .o_aer_req     (o_aer_req),
    .o_aer_time    (o_aer_time),
    .o_aer_addr    (o_aer_addr),
    .i_done_req    (i_done_req),
    .o_done_ack    (o_done_ack),
    .o_window_done (o_window_done),
    .o_evt_count   (o_evt_count),
    .o_err         (o_err),
    .o_busy        (o_busy)
  );

  always #5 local_clk = ~local_clk;

  task automatic tick;
    @(posedge local_clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset;
    i_evt_valid = 0; i_window_end = 0; i_clear = 0; i_done_req = '0;
    i_evt_time = '0; i_evt_addr = '0;
    rst_n = 0;
    tick; tick;
    @(negedge local_clk) rst_n = 1;
    tick;
  endtask

  task automatic test_reset;
    do_reset;
    rst_n = 0;
    tick;
    n_chk++; if (o_evt_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", o_evt_ready); end
    n_chk++; if (o_aer_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", o_aer_req); end
    n_chk++; if ({o_aer_time, o_aer_addr} !== 18'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", {o_aer_time, o_aer_addr}); end
    n_chk++; if ({o_done_ack, o_window_done, o_err, o_busy} !== 7'h0) begin n_fail++; $display("FAIL rst_flags: got %b want 0", {o_done_ack, o_window_done, o_err, o_busy}); end
    n_chk++; if (o_evt_count !== 16'h0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", o_evt_count); end
    @(negedge local_clk) rst_n = 1;
    tick;
  endtask

  // PE done arrives at +3,+5,+6,+9 cycles after the req pulse.
  task automatic test_single;
    do_reset;
    i_evt_valid = 1; i_evt_time = 8'h20; i_evt_addr = 10'd5;
    tick;
    i_evt_valid = 0;
    n_chk++; if (o_aer_req !== 1'b0) begin n_fail++; $display("FAIL t1_req_early: got %b want 0", o_aer_req); end
    tick;
    n_chk++; if (o_aer_req !== 1'b1) begin n_fail++; $display("FAIL t1_req: got %b want 1", o_aer_req); end
    n_chk++; if (o_aer_time !== 8'h20 || o_aer_addr !== 10'd5) begin n_fail++; $display("FAIL t1_data: got %h/%h want 20/005", o_aer_time, o_aer_addr); end
    for (int k = 1; k <= 12; k++) begin
      tick;
      n_chk++; if (o_done_ack !== ((k == 10) ? 4'hF : 4'h0)) begin n_fail++; $display("FAIL t1_ack k=%0d: got %h want %h", k, o_done_ack, (k == 10) ? 4'hF : 4'h0); end
      n_chk++; if (o_aer_req !== 1'b0) begin n_fail++; $display("FAIL t1_req_hold k=%0d: got %b want 0", k, o_aer_req); end
      if (k == 10) begin
        n_chk++; if (o_evt_count !== 16'd1) begin n_fail++; $display("FAIL t1_count: got %0d want 1", o_evt_count); end
        n_chk++; if (o_aer_time !== 8'h20 || o_aer_addr !== 10'd5) begin n_fail++; $display("FAIL t1_stable: got %h/%h want 20/005", o_aer_time, o_aer_addr); end
      end
      i_done_req = {k >= 9 && k < 10, k >= 6 && k < 10, k >= 5 && k < 10, k >= 3 && k < 10};
    end
    n_chk++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL t1_busy: got %b want 0", o_busy); end
  endtask

  task automatic test_fifo_full;
    logic [7:0] cap_t [16];
    logic [9:0] cap_a [16];
    int nreq, nack, last_req, min_gap;
    do_reset;
    nreq = 0; nack = 0; last_req = 0; min_gap = 1000;
    for (int i = 0; i < 9; i++) begin
      n_chk++; if (o_evt_ready !== 1'b1) begin n_fail++; $display("FAIL t2_ready i=%0d: got %b want 1", i, o_evt_ready); end
      i_evt_valid = 1; i_evt_time = 8'h10 + 8'(i); i_evt_addr = 10'(i * 3 + 1);
      tick;
      if (o_aer_req) begin
        if (nreq < 16) begin cap_t[nreq] = o_aer_time; cap_a[nreq] = o_aer_addr; end
        last_req = cyc; nreq++;
      end
    end
    n_chk++; if (o_evt_ready !== 1'b0) begin n_fail++; $display("FAIL t2_full: got %b want 0", o_evt_ready); end
    // Push attempt while full must be dropped.
    i_evt_time = 8'h7F; i_evt_addr = 10'h3FF;
    tick;
    i_evt_valid = 0;
    n_chk++; if (o_evt_ready !== 1'b0) begin n_fail++; $display("FAIL t2_still_full: got %b want 0", o_evt_ready); end
    i_done_req = 4'hF;
    for (int k = 0; k < 50; k++) begin
      tick;
      if (o_aer_req) begin
        if (nreq < 16) begin cap_t[nreq] = o_aer_time; cap_a[nreq] = o_aer_addr; end
        if (nreq > 0 && cyc - last_req < min_gap) min_gap = cyc - last_req;
        last_req = cyc; nreq++;
      end
      if (o_done_ack == 4'hF) nack++;
    end
    i_done_req = '0;
    n_chk++; if (nreq !== 9) begin n_fail++; $display("FAIL t2_nreq: got %0d want 9", nreq); end
    n_chk++; if (nack !== 9) begin n_fail++; $display("FAIL t2_nack: got %0d want 9", nack); end
    for (int i = 0; i < 9 && i < nreq; i++) begin
      n_chk++;
      if (cap_t[i] !== 8'h10 + 8'(i) || cap_a[i] !== 10'(i * 3 + 1)) begin
        n_fail++; $display("FAIL t2_order i=%0d: got %h/%h want %h/%h", i, cap_t[i], cap_a[i], 8'h10 + 8'(i), 10'(i * 3 + 1));
      end
    end
    n_chk++; if (min_gap < 4) begin n_fail++; $display("FAIL t2_gap: got %0d want >=4", min_gap); end
    n_chk++; if (o_evt_count !== 16'd9) begin n_fail++; $display("FAIL t2_count: got %0d want 9", o_evt_count); end
    n_chk++; if (o_busy !== 1'b0 || o_err !== 1'b0) begin n_fail++; $display("FAIL t2_idle: got busy=%b err=%b want 0/0", o_busy, o_err); end
  endtask

  task automatic test_window;
    int nack, nwd, ack3, wdk;
    do_reset;
    nack = 0; nwd = 0; ack3 = -100; wdk = -1;
    i_done_req = 4'hF;
    for (int i = 0; i < 3; i++) begin
      i_evt_valid = 1; i_evt_time = 8'h30 + 8'(i); i_evt_addr = 10'(100 + i);
      i_window_end = (i == 0);
      tick;
    end
    i_evt_valid = 0; i_window_end = 0;
    for (int k = 0; k < 40; k++) begin
      if (o_done_ack == 4'hF) begin nack++; if (nack == 3) ack3 = k; end
      if (o_window_done) begin
        nwd++; wdk = k;
        n_chk++; if (nack !== 3) begin n_fail++; $display("FAIL t3_wd_early: got %0d acks want 3", nack); end
      end
      tick;
    end
    i_done_req = '0;
    n_chk++; if (nwd !== 1) begin n_fail++; $display("FAIL t3_wd_count: got %0d want 1", nwd); end
    n_chk++; if (wdk - ack3 !== 2) begin n_fail++; $display("FAIL t3_wd_delay: got %0d want 2", wdk - ack3); end
    n_chk++; if (o_evt_count !== 16'd3) begin n_fail++; $display("FAIL t3_count: got %0d want 3", o_evt_count); end
  endtask

  // Pass 0: PE2 silent -> timeout error. Pass 1: clear lands on the timeout edge and wins.
  task automatic test_timeout;
    logic exp_err;
    do_reset;
    i_done_req = 4'b1011;
    for (int p = 0; p < 2; p++) begin
      i_evt_valid = 1; i_evt_time = 8'h40 + 8'(p); i_evt_addr = 10'h3F0;
      tick;
      i_evt_valid = 0;
      tick;
      n_chk++; if (o_aer_req !== 1'b1) begin n_fail++; $display("FAIL t4_req p=%0d: got %b want 1", p, o_aer_req); end
      for (int k = 1; k <= 18; k++) begin
        tick;
        exp_err = (p == 0) && (k >= 17);
        n_chk++; if (o_err !== exp_err) begin n_fail++; $display("FAIL t4_err p=%0d k=%0d: got %b want %b", p, k, o_err, exp_err); end
        n_chk++; if (o_done_ack !== ((k == 17) ? 4'hF : 4'h0)) begin n_fail++; $display("FAIL t4_ack p=%0d k=%0d: got %h", p, k, o_done_ack); end
        n_chk++; if (o_evt_count !== {15'd0, exp_err}) begin n_fail++; $display("FAIL t4_count p=%0d k=%0d: got %0d want %0d", p, k, o_evt_count, exp_err); end
        i_clear = (p == 1) && (k == 16);
      end
      if (p == 0) begin
        i_clear = 1;
        tick;
        i_clear = 0;
        n_chk++; if (o_err !== 1'b0 || o_evt_count !== 16'd0) begin n_fail++; $display("FAIL t4_clear: got err=%b count=%0d want 0/0", o_err, o_evt_count); end
      end
    end
    i_done_req = '0;
  endtask

  task automatic test_reset_mid;
    do_reset;
    for (int i = 0; i < 3; i++) begin
      i_evt_valid = 1; i_evt_time = 8'h55 + 8'(i); i_evt_addr = 10'h2AA;
      tick;
    end
    i_evt_valid = 0;
    tick; tick;
    n_chk++; if (o_busy !== 1'b1 || o_aer_time !== 8'h55) begin n_fail++; $display("FAIL t5_pre: got busy=%b time=%h want 1/55", o_busy, o_aer_time); end
    #2 rst_n = 0;
    #1;
    n_chk++; if ({o_aer_req, o_done_ack, o_window_done, o_err, o_busy} !== 8'h0) begin n_fail++; $display("FAIL t5_flags: got %b want 0", {o_aer_req, o_done_ack, o_window_done, o_err, o_busy}); end
    n_chk++; if ({o_aer_time, o_aer_addr} !== 18'h0) begin n_fail++; $display("FAIL t5_data: got %h want 0", {o_aer_time, o_aer_addr}); end
    n_chk++; if (o_evt_ready !== 1'b1) begin n_fail++; $display("FAIL t5_ready: got %b want 1", o_evt_ready); end
    @(negedge local_clk) rst_n = 1;
    for (int k = 0; k < 10; k++) begin
      tick;
      n_chk++; if (o_aer_req !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL t5_post k=%0d: got req=%b busy=%b want 0/0", k, o_aer_req, o_busy); end
    end
  endtask

  // PE0 holds done high throughout; a full done pattern during the issue cycle is ignored.
  task automatic test_done_sticky;
    do_reset;
    i_done_req = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      i_evt_valid = 1; i_evt_time = 8'h60 + 8'(i); i_evt_addr = 10'(200 + i);
      tick;
    end
    i_evt_valid = 0;
    n_chk++; if (o_aer_req !== 1'b1 || o_aer_time !== 8'h60) begin n_fail++; $display("FAIL t6_req0: got %b/%h want 1/60", o_aer_req, o_aer_time); end
    for (int k = 1; k <= 12; k++) begin
      tick;
      n_chk++; if (o_done_ack !== ((k == 3 || k == 11) ? 4'hF : 4'h0)) begin n_fail++; $display("FAIL t6_ack k=%0d: got %h", k, o_done_ack); end
      n_chk++; if (o_aer_req !== (k == 5)) begin n_fail++; $display("FAIL t6_req k=%0d: got %b want %b", k, o_aer_req, k == 5); end
      if (k == 2 || k == 5 || k == 10) i_done_req = 4'hF;
      else if (k == 3 || k == 6 || k == 11) i_done_req = 4'b0001;
    end
    n_chk++; if (o_evt_count !== 16'd2 || o_busy !== 1'b0) begin n_fail++; $display("FAIL t6_end: got count=%0d busy=%b want 2/0", o_evt_count, o_busy); end
    i_done_req = '0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_fifo_full;
    test_window;
    test_timeout;
    test_reset_mid;
    test_done_sticky;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
